sync_fifo: RTL and testbench

Single-clock synchronous FIFO with registered read data and full/empty status flags. It is the byte-lane buffer used by the AHB-to-UART bridge: four instances buffer TX bytes and four buffer RX bytes, one instance per byte lane of a 32-bit word. The block is generic in width and depth and has no knowledge of the bus protocol.

---
 rtl/sync_fifo.sv | 145 ++++++++++++++
 tb/tb_sync_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock synchronous FIFO with registered read data and full/empty
// status flags. Generic in width and depth; depth need not be a power of two.
// One instance serves one byte lane of the AHB-to-UART bridge.
//
// Parameters:
//   DATA_WIDTH  width of each entry in bits (default 8)
//   DATA_DEPTH  number of entries, >= 2 (default 8)
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rstn       in   asynchronous active-low reset
//   data_in    in   write data
//   wr_en      in   write request (dropped while full)
//   rd_en      in   read request (ignored while empty)
//   data_out   out  registered read data, valid the edge after an accepted read
//   full       out  FIFO holds DATA_DEPTH entries
//   empty      out  FIFO holds no entries
//   overflow   out  sticky: write attempted while full
//   underflow  out  sticky: read attempted while empty
//
// Optional feature macro: SYNC_FIFO_ERR_EN adds the overflow/underflow
// ports and their sticky flag logic. Without it the data path is identical.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
`ifdef SYNC_FIFO_ERR_EN
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic                  empty
`endif
);

  localparam int PTR_W = $clog2(DATA_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DATA_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  full_s, empty_s;
  logic                  wr_accept_s, rd_accept_s;

  // Explicit wrap at DATA_DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Flags come only from the count register, so inputs never reach them.
  assign full_s      = (cnt_q == CNT_FULL);
  assign empty_s     = (cnt_q == CNT_ZERO);
  assign wr_accept_s = wr_en && !full_s;
  assign rd_accept_s = rd_en && !empty_s;

  assign full     = full_s;
  assign empty    = empty_s;
  assign data_out = dout_q;

  // Next-state decode for pointers, occupancy and read data.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (wr_accept_s) begin
      wptr_d = ptr_inc(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_accept_s) begin
      rptr_d = ptr_inc(rptr_q);
      dout_d = mem_q[rptr_q];
    end else begin
      rptr_d = rptr_q;
      dout_d = dout_q;
    end
    case ({wr_accept_s, rd_accept_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control and read-data registers; reset discards contents at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= {PTR_W{1'b0}};
      rptr_q <= {PTR_W{1'b0}};
      cnt_q  <= CNT_ZERO;
      dout_q <= {DATA_WIDTH{1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_q[wptr_q] <= data_in;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, unf_q;

  // Sticky error flags: set on a rejected request, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr_en & full_s);
      unf_q <= unf_q | (rd_en & empty_s);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: directed scenarios plus randomized traffic, checked
// against a queue-based reference model through a scoreboard.
module tb_sync_fifo;
  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] data_out;
  logic         full, empty;
`ifdef SYNC_FIFO_ERR_EN
  logic         overflow, underflow;
`endif

  sync_fifo #(.DATA_WIDTH(W), .DATA_DEPTH(D)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .full      (full),
`ifdef SYNC_FIFO_ERR_EN
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
`else
    .empty     (empty)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dout;
    logic         full;
    logic         empty;
    logic         ovf;
    logic         unf;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mdl_q[$];
  logic [W-1:0] mdl_dout = '0;
  logic         mdl_ovf = 1'b0;
  logic         mdl_unf = 1'b0;
  int           n_checks = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the reference model computes the state the
  // DUT must show after the coming rising edge and queues it for the monitor.
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] din);
    bit   was_full, was_empty;
    exp_t e;
    @(negedge clk);
    #1;
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    was_full  = (mdl_q.size() == D);
    was_empty = (mdl_q.size() == 0);
    if (rd && !was_empty) mdl_dout = mdl_q.pop_front();
    if (wr && !was_full)  mdl_q.push_back(din);
    if (wr && was_full)   mdl_ovf = 1'b1;
    if (rd && was_empty)  mdl_unf = 1'b1;
    e.dout  = mdl_dout;
    e.full  = (mdl_q.size() == D);
    e.empty = (mdl_q.size() == 0);
    e.ovf   = mdl_ovf;
    e.unf   = mdl_unf;
    exp_q.push_back(e);
  endtask

  // Monitor: after each edge the DUT presents its outputs; compare them.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("data_out", 32'(data_out), 32'(e.dout));
      check("full", 32'(full), 32'(e.full));
      check("empty", 32'(empty), 32'(e.empty));
`ifdef SYNC_FIFO_ERR_EN
      check("overflow", 32'(overflow), 32'(e.ovf));
      check("underflow", 32'(underflow), 32'(e.unf));
`endif
    end
  end

  task automatic wait_drained();
    int k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] v;
    #22;
    rstn = 1'b1;
    #1;
    reset_checks("reset");

    // Read on empty: ignored, data_out stays 0
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Fill, overflow attempt, drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h11 + i));
    step(1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);

    // Simultaneous read/write with 3 entries held
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h31 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

    // Full + read + write: only the read happens
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);

    // Empty + read + write: only the write happens
    step(1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-stream with 4 entries held
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b0, 1'b0, 8'h00);
    wait_drained();
    rstn = 1'b0;
    #1;
    reset_checks("async_reset");
    mdl_q.delete();
    mdl_dout = '0;
    mdl_ovf  = 1'b0;
    mdl_unf  = 1'b0;
    #1;
    rstn = 1'b1;
    step(1'b1, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 8'h5B);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);

    // Randomized traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 400; i++) begin
      bit heavy_wr;
      heavy_wr = ((i / 40) % 2) == 0;
      v = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 99) < (heavy_wr ? 80 : 30)),
           ($urandom_range(0, 99) < (heavy_wr ? 30 : 80)), v);
    end
    step(1'b0, 1'b0, 8'h00);
    wait_drained();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
